fir_filter_param: RTL and testbench
===================================

# fir_filter_param

Parametrised, runtime-loadable FIR filter; successor to the fixed 80-tap, 8-bit FIR. It processes one sample per handshake with LANES multiply-accumulates per cycle. Coefficients come from a write port, and output uses round-half-up and saturation. It sits between the sample source and the downstream DSP/DAC path, with valid/ready on both sides.

## Interface
- DATA_W, 8: input and output sample width, signed.
- COEF_W, 8: coefficient width, signed.
- TAPS, 80: number of taps; must be a multiple of LANES.
- LANES, 4: MACs per cycle; NGRP = TAPS/LANES.
- SHIFT, 8: right shift applied to the accumulator before output; must be ≥1.
- ACC_W, DATA_W+COEF_W+$clog2(TAPS): accumulator width.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  signed input sample.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- out_data  out  DATA_W  signed filtered sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  tap index, 0 = newest sample.
- coef_wdata  in  COEF_W  signed coefficient.
- busy  out  1  high in ACCUM or FINAL.
- sat_flag  out  1  sticky; set when any output saturates.

## Operation
States are IDLE, ACCUM and FINAL.

- **IDLE**
  - in_ready=1.
  - On in_valid: delay[0]<=in_data, delay[i]<=delay[i-1], acc<=0, grp<=0, go to ACCUM.
- **ACCUM**
  - acc <= acc + Σ_{j<LANES} coef[grp*LANES+j]*delay[grp*LANES+j].
  - grp<=grp+1.
  - When grp==NGRP-1, go to FINAL.
- **FINAL**
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT, computed at full width (arithmetic shift).
  - Clamp r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; if clamped, sat_flag<=1.
  - If !out_valid or out_ready: out_data<=clamped r, out_valid<=1, go to IDLE.
  - Otherwise stay in FINAL (backpressure stall); acc is held.
- **Output handshake**
  - out_valid clears on out_valid&&out_ready, unless FINAL loads a new result on the same edge; in that case it stays 1.
  - out_data is stable while out_valid && !out_ready.
- **Coefficients**
  - coef_we is honoured only in IDLE; it is ignored in ACCUM and FINAL.
  - A write in IDLE on the same edge as a sample accept applies to that sample's computation.
  - coef_addr ≥ TAPS is ignored.
- **Arithmetic**
  - Products are full precision, DATA_W+COEF_W bits, and sign-extended to ACC_W.
  - ACC_W cannot overflow for any inputs.
- **Reset**
  - Clears coefficients, delay line, acc, grp, out_data, out_valid and sat_flag to 0, and sets state to IDLE.
  - A reset during ACCUM or FINAL aborts the computation with no output.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, sat_flag=0.
- Latency: the accept edge is t0. ACCUM spans NGRP cycles. out_valid rises at edge t0+NGRP+1, which is 21 with defaults, with no backpressure.
- Throughput: one sample per NGRP+2 cycles (22 with defaults), since IDLE lasts at least one cycle.
- in_ready is a registered function of state only; it never combinationally depends on in_valid or out_ready.
- Back-to-back: a new sample is accepted in the IDLE cycle right after FINAL, even while the previous out_valid is still pending.
- A second result waits in FINAL until the first is consumed. No result is ever dropped or overwritten.

## Test plan
- **Impulse response**
  - Stimulus: load coef[n]=4n+4 for n<31, the rest 0; feed 64 then zeros.
  - Required response: outputs 1,2,…,31 then 0; out_valid 21 cycles after each accept.
- **Rounding**
  - Stimulus: coef[0]=1 with samples 127 and -128; then coef[0]=2 with sample 64; other coefs 0.
  - Required response: outputs 0, 0 and 1 respectively.
- **Saturation**
  - Stimulus: all coefs 127; steady input 127, then steady input -128.
  - Required response: outputs 127 and -128; sat_flag=1 and stays 1 until rst.
- **Backpressure**
  - Stimulus: hold out_ready=0 across two completed samples.
  - Required response: first result held stable; block stalls in FINAL; in_ready=0; no loss. After out_ready=1, both results appear in order.
- **Coefficient write gating**
  - Stimulus: coef_we during ACCUM.
  - Required response: the write is ignored and the current and next outputs are unchanged. The same write issued in IDLE changes the next output.
- **Reset mid-operation**
  - Stimulus: assert rst at grp=10.
  - Required response: next edge gives out_valid=0, in_ready=1, busy=0. A following impulse gives all-zero output because the coefs were cleared.

Source files
------------

// File: rtl/fir_filter_param.sv
// Runtime-loadable FIR filter: LANES MACs per cycle over NGRP groups, then
// round-half-up, arithmetic shift and saturation into a valid/ready output stage.
module fir_filter_param #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 80,
  parameter int LANES  = 4,
  parameter int SHIFT  = 8,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     busy,
  output logic                     sat_flag
);

  localparam int NGRP = TAPS / LANES;
  localparam int AW   = $clog2(TAPS);
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int PW   = DATA_W + COEF_W;

  localparam logic [GW-1:0]          GRP_LAST = GW'(NGRP - 1);
  localparam logic [AW:0]            TAPS_L   = (AW + 1)'(TAPS);
  localparam logic signed [ACC_W:0]  HALF     = (ACC_W + 1)'(2 ** (SHIFT - 1));
  localparam logic signed [ACC_W:0]  MAX_V    = (ACC_W + 1)'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W:0]  MIN_V    = (ACC_W + 1)'(-(2 ** (DATA_W - 1)));
  localparam logic signed [DATA_W-1:0] MAX_D  = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_D  = {1'b1, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL} state_t;

  state_t                    state;
  logic signed [COEF_W-1:0]  coef  [TAPS];
  logic signed [DATA_W-1:0]  delay [TAPS];
  logic signed [ACC_W-1:0]   acc;
  logic [GW-1:0]             grp;

  logic signed [PW-1:0]      lane_prod [LANES];
  logic signed [ACC_W-1:0]   lane_sum;

  // One product per lane; lane gi of group grp covers tap grp*LANES+gi.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [AW-1:0] tap_idx;
    assign tap_idx       = AW'(int'(grp) * LANES + gi);
    assign lane_prod[gi] = coef[tap_idx] * delay[tap_idx];
  end

  always_comb begin
    lane_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_sum = lane_sum + ACC_W'(lane_prod[j]);
    end
  end

  // One extra bit so the rounding constant can never wrap the accumulator.
  logic signed [ACC_W:0]     acc_ext;
  logic signed [ACC_W:0]     rnd_sum;
  logic signed [ACC_W:0]     rnd;
  logic                      sat_hi;
  logic                      sat_lo;
  logic signed [DATA_W-1:0]  clamped;

  assign acc_ext = {acc[ACC_W-1], acc};
  assign rnd_sum = acc_ext + HALF;
  assign rnd     = rnd_sum >>> SHIFT;
  assign sat_hi  = rnd > MAX_V;
  assign sat_lo  = rnd < MIN_V;

  always_comb begin
    clamped = rnd[DATA_W-1:0];
    if (sat_hi) begin
      clamped = MAX_D;
    end else if (sat_lo) begin
      clamped = MIN_D;
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      grp       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        coef[i]  <= '0;
        delay[i] <= '0;
      end
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (coef_we && ({1'b0, coef_addr} < TAPS_L)) begin
            coef[coef_addr] <= coef_wdata;
          end
          if (in_valid) begin
            delay[0] <= in_data;
            for (int i = 1; i < TAPS; i++) begin
              delay[i] <= delay[i-1];
            end
            acc   <= '0;
            grp   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + lane_sum;
          grp <= grp + 1'b1;
          if (grp == GRP_LAST) begin
            state <= FINAL;
          end
        end
        FINAL: begin
          // Load only when the output register is free or being drained this edge.
          if (!out_valid || out_ready) begin
            out_data  <= clamped;
            out_valid <= 1'b1;
            if (sat_hi || sat_lo) begin
              sat_flag <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_param.sv
// Bench for fir_filter_param: directed scenarios plus randomized traffic, all
// checked every cycle against a convolution-level reference model.
module tb_fir_filter_param;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 80;
  localparam int LANES  = 4;
  localparam int SHIFT  = 8;
  localparam int NGRP   = TAPS / LANES;
  localparam int AW     = $clog2(TAPS);

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic signed [DATA_W-1:0] in_data = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic                     coef_we = 1'b0;
  logic [AW-1:0]            coef_addr = '0;
  logic signed [COEF_W-1:0] coef_wdata = '0;
  logic                     busy;
  logic                     sat_flag;

  fir_filter_param #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .LANES(LANES), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of accepted samples and a coefficient table;
  // each result is the plain convolution, rounded and clamped.
  int  m_coef [TAPS];
  int  m_hist [TAPS];
  int  m_state;  // 0 idle, 1 accumulating, 2 waiting to emit
  int  m_cnt;
  int  m_res;
  int  m_od;
  bit  m_res_sat;
  bit  m_ov;
  bit  m_sat;
  bit  m_live = 1'b0;
  int  got [$];

  function automatic void model_compute();
    longint acc;
    longint r;
    acc = 0;
    for (int n = 0; n < TAPS; n++) acc += longint'(m_coef[n]) * longint'(m_hist[n]);
    r = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    m_res_sat = 1'b0;
    if (r > 127) begin
      r = 127;
      m_res_sat = 1'b1;
    end else if (r < -128) begin
      r = -128;
      m_res_sat = 1'b1;
    end
    m_res = int'(r);
  endfunction

  always @(posedge clk) begin
    bit old_ov;
    if (!rst && m_live && out_valid && out_ready) got.push_back(int'(out_data));
    if (rst) begin
      m_live = 1'b1;
      m_state = 0; m_cnt = 0; m_ov = 1'b0; m_od = 0; m_sat = 1'b0;
      for (int n = 0; n < TAPS; n++) begin
        m_coef[n] = 0;
        m_hist[n] = 0;
      end
    end else if (m_live) begin
      old_ov = m_ov;
      if (m_ov && out_ready) m_ov = 1'b0;
      case (m_state)
        0: begin
          if (coef_we && int'(coef_addr) < TAPS) m_coef[coef_addr] = int'(coef_wdata);
          if (in_valid) begin
            for (int n = TAPS - 1; n > 0; n--) m_hist[n] = m_hist[n-1];
            m_hist[0] = int'(in_data);
            model_compute();
            m_state = 1;
            m_cnt = NGRP;
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) m_state = 2;
        end
        default: begin
          if (!old_ov || out_ready) begin
            m_od = m_res;
            m_ov = 1'b1;
            if (m_res_sat) m_sat = 1'b1;
            m_state = 0;
          end
        end
      endcase
    end
    #1;
    if (m_live) begin
      chk("in_ready", int'(in_ready), int'(m_state == 0));
      chk("busy", int'(busy), int'(m_state != 0));
      chk("out_valid", int'(out_valid), int'(m_ov));
      chk("out_data", int'(out_data), m_od);
      chk("sat_flag", int'(sat_flag), int'(m_sat));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 300) begin
      cyc();
      n++;
    end
    chk("in_ready_wait", int'(in_ready), 1);
  endtask

  task automatic wcoef_raw(input int a, input int v);
    coef_we = 1'b1;
    coef_addr = AW'(a);
    coef_wdata = COEF_W'(v);
    cyc();
    coef_we = 1'b0;
  endtask

  task automatic wcoef(input int a, input int v);
    wait_idle();
    wcoef_raw(a, v);
  endtask

  task automatic send(input int v);
    wait_idle();
    in_valid = 1'b1;
    in_data = DATA_W'(v);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k = 0;
    while (got.size() < n && k < 5000) begin
      cyc();
      k++;
    end
    chk("result_count", got.size(), n);
  endtask

  task automatic chk_got(input string name, input int idx, input int exp);
    chk(name, (idx < got.size()) ? got[idx] : 9999, exp);
  endtask

  initial begin
    int lat;
    cyc(3);
    rst = 1'b0;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_sat", int'(sat_flag), 0);

    // Impulse response
    for (int n = 0; n < 31; n++) wcoef(n, 4 * n + 4);
    got.delete();
    send(64);
    lat = 0;
    while (!out_valid && lat < 100) begin
      cyc();
      lat++;
    end
    chk("latency", lat, 21);
    for (int k = 1; k < 32; k++) send(0);
    wait_got(32);
    for (int k = 0; k < 32; k++) chk_got("impulse", k, (k < 31) ? k + 1 : 0);
    $display("impulse: %0d outputs collected, first=%0d last=%0d", got.size(), got[0], got[got.size()-1]);

    // Rounding
    do_reset();
    wcoef(0, 1);
    got.delete();
    send(127);
    send(-128);
    wait_got(2);
    wcoef(0, 2);
    send(64);
    wait_got(3);
    chk_got("round_127", 0, 0);
    chk_got("round_m128", 1, 0);
    chk_got("round_64", 2, 1);
    $display("rounding: outputs %0d %0d %0d", got[0], got[1], got[2]);

    // Saturation
    do_reset();
    for (int n = 0; n < TAPS; n++) wcoef(n, 127);
    got.delete();
    repeat (10) send(127);
    repeat (45) send(-128);
    wait_got(55);
    chk_got("sat_first", 0, 63);
    chk_got("sat_pos", 9, 127);
    chk_got("sat_neg", 54, -128);
    chk("sat_flag_set", int'(sat_flag), 1);
    cyc(50);
    chk("sat_flag_sticky", int'(sat_flag), 1);
    $display("saturation: pos=%0d neg=%0d sat_flag=%0d", got[9], got[54], sat_flag);

    // Backpressure
    do_reset();
    chk("sat_flag_cleared", int'(sat_flag), 0);
    wcoef(0, 64);
    wcoef(1, 128 - 1);
    wcoef(1, 64 * 2 - 1);
    got.delete();
    out_ready = 1'b0;
    send(8);
    send(20);
    cyc(30);
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_busy", int'(busy), 1);
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_held_data", int'(out_data), 2);
    out_ready = 1'b1;
    wait_got(2);
    chk_got("bp_first", 0, 2);
    chk_got("bp_second", 1, 9);
    $display("backpressure: outputs %0d %0d", got[0], got[1]);

    // Coefficient write gating
    do_reset();
    wcoef(0, 100);
    got.delete();
    send(100);
    cyc(2);
    wcoef_raw(0, 50);
    wcoef_raw(1, 127);
    send(100);
    wait_got(2);
    wcoef(0, 50);
    wcoef(100, 127);
    send(100);
    wait_got(3);
    chk_got("gate_first", 0, 39);
    chk_got("gate_second", 1, 39);
    chk_got("gate_idle_write", 2, 20);
    $display("coef gating: outputs %0d %0d %0d", got[0], got[1], got[2]);

    // Reset mid-operation
    wcoef(0, 100);
    got.delete();
    send(50);
    cyc(10);
    rst = 1'b1;
    cyc();
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    send(64);
    wait_got(1);
    chk_got("midrst_impulse", 0, 0);
    cyc(5);
    chk("midrst_no_extra", got.size(), 1);
    $display("reset mid-op: outputs after reset=%0d value=%0d", got.size(), got[0]);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < TAPS; n++) wcoef(n, int'($urandom_range(255)) - 128);
    got.delete();
    for (int c = 0; c < 1500; c++) begin
      in_valid   = ($urandom_range(3) != 0);
      in_data    = DATA_W'($urandom_range(255));
      coef_we    = ($urandom_range(7) == 0);
      coef_addr  = AW'($urandom_range(127));
      coef_wdata = COEF_W'($urandom_range(255));
      out_ready  = ($urandom_range(3) != 0);
      cyc();
    end
    in_valid = 1'b0;
    coef_we = 1'b0;
    out_ready = 1'b1;
    cyc(60);
    chk("random_drained", int'(out_valid), 0);
    $display("random: %0d results consumed", got.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
